// File: rtl/mcpu_alu_pkg.sv
// rtl/mcpu_alu_pkg.sv - shared opcodes, FSM state encoding and width helper for the MCPU sequential ALU
package mcpu_alu_pkg;

  // Opcode values, compared against opcode fields of width CMD_SIZE.
  localparam int OP_AND = 0;
  localparam int OP_OR  = 1;
  localparam int OP_XOR = 2;
  localparam int OP_ADD = 3;
  localparam int OP_SUB = 4;
  localparam int OP_SHL = 5;
  localparam int OP_SHR = 6;
  localparam int OP_MUL = 7;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EXEC     = 2'd1,
    MUL_ITER = 2'd2,
    DONE     = 2'd3
  } state_e;

  // Number of r2 bits that form the shift amount for a given word size.
  function automatic int shamt_w(input int word_size);
    return $clog2(word_size);
  endfunction

endpackage

// File: rtl/mcpu_alu_comb.sv
// rtl/mcpu_alu_comb.sv - combinational AND/OR/XOR/ADD/SUB/SHL/SHR with carry and overflow
//   op    : opcode (OP_AND..OP_SHR; anything else yields zero)
//   a, b  : operands; shifts use only the low shamt_w(WORD_SIZE) bits of b
//   res   : wrap-around result
//   carry : ADD carry-out / SUB borrow, 0 otherwise
//   ovf   : ADD/SUB signed overflow, 0 otherwise
module mcpu_alu_comb
  import mcpu_alu_pkg::*;
#(
  parameter int CMD_SIZE  = 3,
  parameter int WORD_SIZE = 8
) (
  input  logic [CMD_SIZE-1:0]  op,
  input  logic [WORD_SIZE-1:0] a,
  input  logic [WORD_SIZE-1:0] b,
  output logic [WORD_SIZE-1:0] res,
  output logic                 carry,
  output logic                 ovf
);

  localparam int SHAMT_W = shamt_w(WORD_SIZE);
  localparam int MSB     = WORD_SIZE - 1;

  logic [WORD_SIZE:0]   sum;
  logic [WORD_SIZE:0]   diff;
  logic [SHAMT_W-1:0]   shamt;

  assign sum   = {1'b0, a} + {1'b0, b};
  // Bit WORD_SIZE of the extended difference is the unsigned borrow.
  assign diff  = {1'b0, a} - {1'b0, b};
  assign shamt = b[SHAMT_W-1:0];

  always_comb begin
    res   = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    case (op)
      CMD_SIZE'(OP_AND): res = a & b;
      CMD_SIZE'(OP_OR):  res = a | b;
      CMD_SIZE'(OP_XOR): res = a ^ b;
      CMD_SIZE'(OP_ADD): begin
        res   = sum[MSB:0];
        carry = sum[WORD_SIZE];
        ovf   = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      CMD_SIZE'(OP_SUB): begin
        res   = diff[MSB:0];
        carry = diff[WORD_SIZE];
        ovf   = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      CMD_SIZE'(OP_SHL): res = a << shamt;
      CMD_SIZE'(OP_SHR): res = a >> shamt;
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/mcpu_seq_alu.sv
// rtl/mcpu_seq_alu.sv - sequential ALU with iterative shift-add multiply and start/busy/done handshake
//   CLK, RESET          : clock (rising edge), asynchronous active-high reset
//   start, opcode       : request and operation select, sampled only when idle
//   r1, r2              : operands A and B
//   busy                : from the accepting edge until the edge at which done rises
//   done                : one-cycle pulse, out/flags valid from here until next accepted start
//   out                 : registered result
//   OVERFLOW/CARRY/ZERO : registered flags
module mcpu_seq_alu
  import mcpu_alu_pkg::*;
#(
  parameter int CMD_SIZE  = 3,
  parameter int WORD_SIZE = 8
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 start,
  input  logic [CMD_SIZE-1:0]  opcode,
  input  logic [WORD_SIZE-1:0] r1,
  input  logic [WORD_SIZE-1:0] r2,
  output logic                 busy,
  output logic                 done,
  output logic [WORD_SIZE-1:0] out,
  output logic                 OVERFLOW,
  output logic                 CARRY,
  output logic                 ZERO
);

  localparam int W     = WORD_SIZE;
  localparam int CNT_W = shamt_w(WORD_SIZE) + 1;

  state_e              state_q, state_d;
  logic [CMD_SIZE-1:0] op_q, op_d;
  logic [W-1:0]        a_q, a_d;
  logic [W-1:0]        b_q, b_d;

  logic [2*W-1:0]      acc_q, acc_d;
  logic [2*W-1:0]      mcand_q, mcand_d;
  logic [W-1:0]        mplier_q, mplier_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [W-1:0]        out_q, out_d;
  logic                ovf_q, ovf_d;
  logic                carry_q, carry_d;
  logic                zero_q, zero_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [W-1:0]        alu_res;
  logic                alu_carry;
  logic                alu_ovf;

  mcpu_alu_comb #(
    .CMD_SIZE  (CMD_SIZE),
    .WORD_SIZE (WORD_SIZE)
  ) u_alu_comb (
    .op    (op_q),
    .a     (a_q),
    .b     (b_q),
    .res   (alu_res),
    .carry (alu_carry),
    .ovf   (alu_ovf)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
      ovf_q    <= 1'b0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      ovf_q    <= ovf_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    ovf_d    = ovf_q;
    carry_d  = carry_q;
    zero_d   = zero_q;

    case (state_q)
      IDLE: begin
        // The done pulse lands in IDLE (it trails the DONE state by one edge),
        // so a start coinciding with it must still be refused.
        if (start && !done_q) begin
          op_d = opcode;
          a_d  = r1;
          b_d  = r2;
          if (opcode == CMD_SIZE'(OP_MUL)) begin
            acc_d    = '0;
            mcand_d  = {{W{1'b0}}, r1};
            mplier_d = r2;
            cnt_d    = '0;
            state_d  = MUL_ITER;
          end else begin
            state_d  = EXEC;
          end
        end
      end

      EXEC: begin
        out_d   = alu_res;
        carry_d = alu_carry;
        ovf_d   = alu_ovf;
        zero_d  = (alu_res == '0);
        state_d = DONE;
      end

      MUL_ITER: begin
        // WORD_SIZE add/shift steps, then one extra cycle to publish the product.
        if (cnt_q == CNT_W'(W)) begin
          out_d   = acc_q[W-1:0];
          ovf_d   = |acc_q[2*W-1:W];
          carry_d = 1'b0;
          zero_d  = (acc_q[W-1:0] == '0);
          state_d = DONE;
        end else begin
          if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
          end
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CNT_W'(1);
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs are registered: busy follows the next state, done
  // trails the DONE state by one edge so that it coincides with busy falling.
  assign busy_d = (state_d != IDLE);
  assign done_d = (state_q == DONE);

  assign busy     = busy_q;
  assign done     = done_q;
  assign out      = out_q;
  assign OVERFLOW = ovf_q;
  assign CARRY    = carry_q;
  assign ZERO     = zero_q;

endmodule

// File: tb/tb_mcpu_seq_alu.sv
// tb/tb_mcpu_seq_alu.sv - directed table-driven bench for mcpu_seq_alu
module tb_mcpu_seq_alu;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       start;
  logic [2:0] opcode;
  logic [7:0] r1;
  logic [7:0] r2;
  logic       busy;
  logic       done;
  logic [7:0] out;
  logic       OVERFLOW;
  logic       CARRY;
  logic       ZERO;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  mcpu_seq_alu #(
    .CMD_SIZE  (3),
    .WORD_SIZE (8)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .start    (start),
    .opcode   (opcode),
    .r1       (r1),
    .r2       (r2),
    .busy     (busy),
    .done     (done),
    .out      (out),
    .OVERFLOW (OVERFLOW),
    .CARRY    (CARRY),
    .ZERO     (ZERO)
  );

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] y;
    logic       v;
    logic       c;
    logic       z;
    int         lat;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_out"}, out, 0);
    check({tag, "_ovf"}, OVERFLOW, 0);
    check({tag, "_carry"}, CARRY, 0);
    check({tag, "_zero"}, ZERO, 0);
  endtask

  // Issue one operation; returns on the negedge where done is first seen,
  // with lat = edges after the accepting edge (-1 on timeout).
  task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input string tag, output int lat);
    @(negedge CLK);
    start = 1'b1; opcode = op; r1 = a; r2 = b;
    @(negedge CLK);
    start = 1'b0;
    check({tag, "_busy_accept"}, busy, 1);
    lat = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge CLK);
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int ndone;
    logic [7:0] seen_out;

    vecs[0]  = '{3'd3, 8'h7F, 8'h01, 8'h80, 1'b1, 1'b0, 1'b0, 2};
    vecs[1]  = '{3'd4, 8'h05, 8'h05, 8'h00, 1'b0, 1'b0, 1'b1, 2};
    vecs[2]  = '{3'd4, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b1, 1'b0, 2};
    vecs[3]  = '{3'd7, 8'd15, 8'd17, 8'hFF, 1'b0, 1'b0, 1'b0, 10};
    vecs[4]  = '{3'd7, 8'd16, 8'd16, 8'h00, 1'b1, 1'b0, 1'b1, 10};
    vecs[5]  = '{3'd5, 8'h81, 8'h09, 8'h02, 1'b0, 1'b0, 1'b0, 2};
    vecs[6]  = '{3'd6, 8'h80, 8'h07, 8'h01, 1'b0, 1'b0, 1'b0, 2};
    vecs[7]  = '{3'd5, 8'h5A, 8'h00, 8'h5A, 1'b0, 1'b0, 1'b0, 2};
    vecs[8]  = '{3'd6, 8'hA5, 8'h08, 8'hA5, 1'b0, 1'b0, 1'b0, 2};
    vecs[9]  = '{3'd0, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 2};
    vecs[10] = '{3'd1, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0, 1'b0, 2};
    vecs[11] = '{3'd2, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, 2};
    vecs[12] = '{3'd3, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b1, 1'b1, 2};
    vecs[13] = '{3'd4, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b0, 1'b0, 2};
    vecs[14] = '{3'd7, 8'd13, 8'd11, 8'h8F, 1'b0, 1'b0, 1'b0, 10};

    RESET = 1'b1; start = 1'b0; opcode = 3'd0; r1 = 8'h00; r2 = 8'h00;
    repeat (2) @(negedge CLK);
    check_all_zero("reset");
    RESET = 1'b0;

    for (int i = 0; i < 15; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, $sformatf("v%0d", i), lat);
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d_out", i), out, vecs[i].y);
      check($sformatf("v%0d_ovf", i), OVERFLOW, vecs[i].v);
      check($sformatf("v%0d_carry", i), CARRY, vecs[i].c);
      check($sformatf("v%0d_zero", i), ZERO, vecs[i].z);
      check($sformatf("v%0d_busy_at_done", i), busy, 0);
      @(negedge CLK);
      check($sformatf("v%0d_done_pulse_end", i), done, 0);
      check($sformatf("v%0d_out_hold", i), out, vecs[i].y);
    end

    // start raised in the done cycle is refused, then accepted one edge later
    issue(3'd3, 8'h10, 8'h20, "dd_first", lat);
    check("dd_first_out", out, 8'h30);
    start = 1'b1; opcode = 3'd3; r1 = 8'h01; r2 = 8'h01;
    @(negedge CLK);
    check("dd_refused_busy", busy, 0);
    @(negedge CLK);
    start = 1'b0;
    check("dd_accept_busy", busy, 1);
    check("dd_out_held", out, 8'h30);
    lat = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge CLK);
      if (done) begin lat = i; break; end
    end
    check("dd_latency", lat, 2);
    check("dd_out", out, 8'h02);
    @(negedge CLK);

    // start while busy is ignored and does not queue
    start = 1'b1; opcode = 3'd7; r1 = 8'd3; r2 = 8'd4;
    @(negedge CLK);
    start = 1'b0;
    @(negedge CLK);
    check("busy_ign_busy", busy, 1);
    start = 1'b1; opcode = 3'd3; r1 = 8'd1; r2 = 8'd1;
    @(negedge CLK);
    start = 1'b0;
    ndone = 0; seen_out = 8'h00;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (done) begin
        if (ndone == 0) seen_out = out;
        ndone++;
      end
    end
    check("busy_ign_done_count", ndone, 1);
    check("busy_ign_out", seen_out, 8'h0C);
    check("busy_ign_ovf", OVERFLOW, 0);

    // reset mid-multiply aborts with no done pulse
    start = 1'b1; opcode = 3'd7; r1 = 8'd200; r2 = 8'd2;
    @(negedge CLK);
    start = 1'b0;
    repeat (3) @(negedge CLK);
    check("abort_busy_before", busy, 1);
    #2 RESET = 1'b1;
    #1;
    check_all_zero("abort");
    @(negedge CLK);
    RESET = 1'b0;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge CLK);
      if (done) ndone++;
    end
    check("abort_no_done", ndone, 0);
    check("abort_out_stays", out, 8'h00);
    issue(3'd3, 8'd2, 8'd3, "post_abort", lat);
    check("post_abort_latency", lat, 2);
    check("post_abort_out", out, 8'h05);
    check("post_abort_zero", ZERO, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
